// File: rtl/tcm_port_arbiter.sv
// Shares one single-ported TCM between instruction fetch and load/store.
// LSU has priority; a starvation counter eventually forces a fetch through.
module tcm_port_arbiter #(
  parameter int ADDR_WIDTH   = 23,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  ifu_req_i,
  input  logic [ADDR_WIDTH-1:0] ifu_addr_i,
  input  logic                  ifu_flush_i,
  output logic                  ifu_gnt_o,
  output logic                  ifu_rvalid_o,
  output logic [31:0]           ifu_rdata_o,
  input  logic                  lsu_req_i,
  input  logic                  lsu_we_i,
  input  logic [3:0]            lsu_be_i,
  input  logic [ADDR_WIDTH-1:0] lsu_addr_i,
  input  logic [31:0]           lsu_wdata_i,
  output logic                  lsu_gnt_o,
  output logic                  lsu_rvalid_o,
  output logic [31:0]           lsu_rdata_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [31:0]           ram_data_o,
  output logic [3:0]            ram_wr_o,
  input  logic [31:0]           ram_data_i
);

  // A zero limit still needs a legal one-bit counter; it simply never moves.
  localparam int CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic             ifu_pend_q, ifu_pend_d;
  logic             lsu_pend_q, lsu_pend_d;
  logic             force_ifu, lsu_gnt, ifu_gnt;

  // NOTE: every signal gets a default before any branch, so no latch is inferred.
  always_comb begin
    force_ifu    = (STARVE_LIMIT != 0) && (starve_cnt_q == CNT_MAX) && ifu_req_i && !ifu_flush_i;
    // Grants are gated by reset so the RAM is never written while held in reset.
    lsu_gnt      = rst_n_i && lsu_req_i && !force_ifu;
    ifu_gnt      = rst_n_i && ifu_req_i && !ifu_flush_i && !lsu_gnt;

    starve_cnt_d = starve_cnt_q;
    if (!ifu_req_i || ifu_flush_i || ifu_gnt) begin
      starve_cnt_d = '0;
    end else if (lsu_gnt && (starve_cnt_q != CNT_MAX)) begin
      starve_cnt_d = starve_cnt_q + CNT_W'(1);
    end

    ifu_pend_d   = ifu_gnt;
    lsu_pend_d   = lsu_gnt;
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      starve_cnt_q <= '0;
      ifu_pend_q   <= 1'b0;
      lsu_pend_q   <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      ifu_pend_q   <= ifu_pend_d;
      lsu_pend_q   <= lsu_pend_d;
    end
  end

  assign ifu_gnt_o    = ifu_gnt;
  assign lsu_gnt_o    = lsu_gnt;

  assign ram_addr_o   = lsu_gnt ? lsu_addr_i : ifu_addr_i;
  assign ram_data_o   = lsu_wdata_i;
  assign ram_wr_o     = (lsu_gnt && lsu_we_i) ? lsu_be_i : 4'b0000;

  // A flush arriving with the response squashes the stale fetch.
  assign ifu_rvalid_o = ifu_pend_q && !ifu_flush_i;
  assign lsu_rvalid_o = lsu_pend_q;
  assign ifu_rdata_o  = ram_data_i;
  assign lsu_rdata_o  = ram_data_i;

endmodule

// File: tb/tb_tcm_port_arbiter.sv
// Self-checking bench for tcm_port_arbiter: directed scenarios plus random
// traffic compared against a rule-level model with a shadow memory.
module tb_tcm_port_arbiter;

  localparam int AW    = 23;
  localparam int LIMIT = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ifu_req, ifu_flush, lsu_req, lsu_we;
  logic [AW-1:0] ifu_addr, lsu_addr;
  logic [3:0]    lsu_be;
  logic [31:0]   lsu_wdata;
  logic          ifu_gnt, ifu_rvalid, lsu_gnt, lsu_rvalid;
  logic [31:0]   ifu_rdata, lsu_rdata, ram_wdata, ram_rdata;
  logic [AW-1:0] ram_addr;
  logic [3:0]    ram_wr;

  // Second instance with STARVE_LIMIT=0 for the pure-priority case.
  logic          ifu_req0, lsu_req0;
  logic          ifu_gnt0, ifu_rvalid0, lsu_gnt0, lsu_rvalid0;
  logic [31:0]   ifu_rdata0, lsu_rdata0, ram_wdata0;
  logic [AW-1:0] ram_addr0;
  logic [3:0]    ram_wr0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  tcm_port_arbiter #(.ADDR_WIDTH(AW), .STARVE_LIMIT(LIMIT)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .ifu_req_i(ifu_req), .ifu_addr_i(ifu_addr), .ifu_flush_i(ifu_flush),
    .ifu_gnt_o(ifu_gnt), .ifu_rvalid_o(ifu_rvalid), .ifu_rdata_o(ifu_rdata),
    .lsu_req_i(lsu_req), .lsu_we_i(lsu_we), .lsu_be_i(lsu_be),
    .lsu_addr_i(lsu_addr), .lsu_wdata_i(lsu_wdata),
    .lsu_gnt_o(lsu_gnt), .lsu_rvalid_o(lsu_rvalid), .lsu_rdata_o(lsu_rdata),
    .ram_addr_o(ram_addr), .ram_data_o(ram_wdata), .ram_wr_o(ram_wr),
    .ram_data_i(ram_rdata)
  );

  tcm_port_arbiter #(.ADDR_WIDTH(AW), .STARVE_LIMIT(0)) dut0 (
    .clk_i(clk), .rst_n_i(rst_n),
    .ifu_req_i(ifu_req0), .ifu_addr_i(ifu_addr), .ifu_flush_i(ifu_flush),
    .ifu_gnt_o(ifu_gnt0), .ifu_rvalid_o(ifu_rvalid0), .ifu_rdata_o(ifu_rdata0),
    .lsu_req_i(lsu_req0), .lsu_we_i(lsu_we), .lsu_be_i(lsu_be),
    .lsu_addr_i(lsu_addr), .lsu_wdata_i(lsu_wdata),
    .lsu_gnt_o(lsu_gnt0), .lsu_rvalid_o(lsu_rvalid0), .lsu_rdata_o(lsu_rdata0),
    .ram_addr_o(ram_addr0), .ram_data_o(ram_wdata0), .ram_wr_o(ram_wr0),
    .ram_data_i(ram_rdata)
  );

  // Read-first RAM with one cycle of registered read latency.
  logic [31:0] mem [0:65535];
  always @(posedge clk) begin
    ram_rdata <= mem[ram_addr[15:0]];
    for (int b = 0; b < 4; b++)
      if (ram_wr[b]) mem[ram_addr[15:0]][8*b +: 8] <= ram_wdata[8*b +: 8];
  end

  // ---------------- Reference model ----------------
  int          m_starve = 0;
  bit          m_ifu_pend = 1'b0;
  bit          m_lsu_pend = 1'b0;
  logic [31:0] m_data;
  logic [31:0] shadow [0:65535];

  function automatic bit f_force();
    return (LIMIT != 0) && (m_starve == LIMIT) && ifu_req && !ifu_flush;
  endfunction
  function automatic bit f_lsu_gnt();
    return rst_n && lsu_req && !f_force();
  endfunction
  function automatic bit f_ifu_gnt();
    return rst_n && ifu_req && !ifu_flush && !f_lsu_gnt();
  endfunction
  function automatic logic [3:0] f_wr();
    return (f_lsu_gnt() && lsu_we) ? lsu_be : 4'b0000;
  endfunction
  function automatic logic [AW-1:0] f_addr();
    return f_lsu_gnt() ? lsu_addr : ifu_addr;
  endfunction
  function automatic bit f_ifu_rv();
    return rst_n && m_ifu_pend && !ifu_flush;
  endfunction
  function automatic bit f_lsu_rv();
    return rst_n && m_lsu_pend;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_starve   <= 0;
      m_ifu_pend <= 1'b0;
      m_lsu_pend <= 1'b0;
    end else begin
      m_lsu_pend <= f_lsu_gnt();
      m_ifu_pend <= f_ifu_gnt();
      m_data     <= shadow[f_addr() & 23'hFFFF];
      if (f_lsu_gnt() && lsu_we)
        for (int b = 0; b < 4; b++)
          if (lsu_be[b]) shadow[lsu_addr[15:0]][8*b +: 8] <= lsu_wdata[8*b +: 8];
      if (!ifu_req || ifu_flush || f_ifu_gnt()) m_starve <= 0;
      else if (f_lsu_gnt() && m_starve < LIMIT) m_starve <= m_starve + 1;
    end
  end

  // ---------------- Stimulus helpers ----------------
  task automatic drive_idle();
    ifu_req = 1'b0; ifu_flush = 1'b0; lsu_req = 1'b0; lsu_we = 1'b0;
    ifu_req0 = 1'b0; lsu_req0 = 1'b0;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [31:0] d);
    @(negedge clk);
    drive_idle();
    lsu_req = 1'b1; lsu_we = 1'b1; lsu_be = 4'hF; lsu_addr = a; lsu_wdata = d;
    #1;
    checks++;
    if (lsu_gnt !== 1'b1) begin errors++; $display("FAIL preload_gnt: got %b expected 1", lsu_gnt); end
  endtask

  // ---------------- Scenarios ----------------
  task automatic test_reset();
    @(negedge clk);
    ifu_req = 1'b1; lsu_req = 1'b1; lsu_we = 1'b1; lsu_be = 4'hF;
    #1;
    checks += 5;
    if (ifu_gnt !== 1'b0)    begin errors++; $display("FAIL reset_ifu_gnt: got %b expected 0", ifu_gnt); end
    if (lsu_gnt !== 1'b0)    begin errors++; $display("FAIL reset_lsu_gnt: got %b expected 0", lsu_gnt); end
    if (ram_wr !== 4'h0)     begin errors++; $display("FAIL reset_ram_wr: got %h expected 0", ram_wr); end
    if (ifu_rvalid !== 1'b0) begin errors++; $display("FAIL reset_ifu_rvalid: got %b expected 0", ifu_rvalid); end
    if (lsu_rvalid !== 1'b0) begin errors++; $display("FAIL reset_lsu_rvalid: got %b expected 0", lsu_rvalid); end
    @(negedge clk);
    drive_idle();
    rst_n = 1'b1;
  endtask

  task automatic test_ifu_read();
    preload(23'h4000, 32'h0000_0013);
    @(negedge clk);
    drive_idle();
    ifu_req = 1'b1; ifu_addr = 23'h4000;
    #1;
    checks += 4;
    if (ifu_gnt !== 1'b1)      begin errors++; $display("FAIL ifu_read_gnt: got %b expected 1", ifu_gnt); end
    if (lsu_gnt !== 1'b0)      begin errors++; $display("FAIL ifu_read_lsu_gnt: got %b expected 0", lsu_gnt); end
    if (ram_wr !== 4'h0)       begin errors++; $display("FAIL ifu_read_wr: got %h expected 0", ram_wr); end
    if (ram_addr !== 23'h4000) begin errors++; $display("FAIL ifu_read_addr: got %h expected 4000", ram_addr); end
    @(negedge clk);
    drive_idle();
    #1;
    checks += 3;
    if (ifu_rvalid !== 1'b1)          begin errors++; $display("FAIL ifu_read_rvalid: got %b expected 1", ifu_rvalid); end
    if (ifu_rdata !== 32'h0000_0013)  begin errors++; $display("FAIL ifu_read_rdata: got %h expected 00000013", ifu_rdata); end
    if (lsu_rvalid !== 1'b0)          begin errors++; $display("FAIL ifu_read_lsu_rvalid: got %b expected 0", lsu_rvalid); end
  endtask

  task automatic test_starvation();
    @(negedge clk);
    drive_idle();
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      ifu_req = 1'b1; lsu_req = 1'b1; lsu_we = 1'b0;
      ifu_addr = 23'h4000; lsu_addr = 23'h0100;
      #1;
      checks += 2;
      if (ifu_gnt !== (i % 5 == 4))
        begin errors++; $display("FAIL starve_ifu_gnt[%0d]: got %b expected %b", i, ifu_gnt, (i % 5 == 4)); end
      if (lsu_gnt !== (i % 5 != 4))
        begin errors++; $display("FAIL starve_lsu_gnt[%0d]: got %b expected %b", i, lsu_gnt, (i % 5 != 4)); end
    end
    @(negedge clk);
    drive_idle();
  endtask

  task automatic test_store_load();
    preload(23'h0100, 32'h1122_3344);
    @(negedge clk);
    drive_idle();
    lsu_req = 1'b1; lsu_we = 1'b1; lsu_be = 4'b0011; lsu_addr = 23'h0100; lsu_wdata = 32'hAABB_CCDD;
    #1;
    checks += 2;
    if (lsu_gnt !== 1'b1)    begin errors++; $display("FAIL store_gnt: got %b expected 1", lsu_gnt); end
    if (ram_wr !== 4'b0011)  begin errors++; $display("FAIL store_wr: got %b expected 0011", ram_wr); end
    @(negedge clk);
    lsu_we = 1'b0;
    #1;
    checks += 3;
    if (lsu_rvalid !== 1'b1)         begin errors++; $display("FAIL store_rvalid: got %b expected 1", lsu_rvalid); end
    if (lsu_rdata !== 32'h1122_3344) begin errors++; $display("FAIL store_old_data: got %h expected 11223344", lsu_rdata); end
    if (ram_wr !== 4'h0)             begin errors++; $display("FAIL load_wr: got %h expected 0", ram_wr); end
    @(negedge clk);
    drive_idle();
    #1;
    checks += 2;
    if (lsu_rvalid !== 1'b1)         begin errors++; $display("FAIL load_rvalid: got %b expected 1", lsu_rvalid); end
    if (lsu_rdata !== 32'h1122_CCDD) begin errors++; $display("FAIL load_new_data: got %h expected 1122ccdd", lsu_rdata); end
  endtask

  task automatic test_flush();
    @(negedge clk);
    drive_idle();
    ifu_req = 1'b1; ifu_addr = 23'h4000;
    #1;
    checks++;
    if (ifu_gnt !== 1'b1) begin errors++; $display("FAIL flush_first_gnt: got %b expected 1", ifu_gnt); end
    @(negedge clk);
    ifu_flush = 1'b1;
    #1;
    checks += 2;
    if (ifu_gnt !== 1'b0)    begin errors++; $display("FAIL flush_blocks_gnt: got %b expected 0", ifu_gnt); end
    if (ifu_rvalid !== 1'b0) begin errors++; $display("FAIL flush_masks_rvalid: got %b expected 0", ifu_rvalid); end
    @(negedge clk);
    ifu_flush = 1'b0;
    #1;
    checks += 2;
    if (ifu_gnt !== 1'b1)    begin errors++; $display("FAIL flush_regrant: got %b expected 1", ifu_gnt); end
    if (ifu_rvalid !== 1'b0) begin errors++; $display("FAIL flush_no_stale: got %b expected 0", ifu_rvalid); end
    @(negedge clk);
    drive_idle();
    #1;
    checks += 2;
    if (ifu_rvalid !== 1'b1)         begin errors++; $display("FAIL flush_after_rvalid: got %b expected 1", ifu_rvalid); end
    if (ifu_rdata !== 32'h0000_0013) begin errors++; $display("FAIL flush_after_rdata: got %h expected 00000013", ifu_rdata); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    drive_idle();
    // Two LSU wins build up the starvation count before the reset.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      ifu_req = 1'b1; lsu_req = 1'b1; lsu_we = 1'b0; ifu_addr = 23'h4000; lsu_addr = 23'h0100;
    end
    @(negedge clk);
    lsu_we = 1'b1; lsu_be = 4'hF; lsu_addr = 23'h0200; lsu_wdata = 32'hDEAD_BEEF;
    #1;
    checks += 2;
    if (lsu_gnt !== 1'b1) begin errors++; $display("FAIL rmid_store_gnt: got %b expected 1", lsu_gnt); end
    if (ram_wr !== 4'hF)  begin errors++; $display("FAIL rmid_store_wr: got %h expected f", ram_wr); end
    #2;
    rst_n = 1'b0;
    #1;
    checks += 4;
    if (lsu_gnt !== 1'b0)    begin errors++; $display("FAIL rmid_lsu_gnt: got %b expected 0", lsu_gnt); end
    if (ifu_gnt !== 1'b0)    begin errors++; $display("FAIL rmid_ifu_gnt: got %b expected 0", ifu_gnt); end
    if (ram_wr !== 4'h0)     begin errors++; $display("FAIL rmid_ram_wr: got %h expected 0", ram_wr); end
    if (lsu_rvalid !== 1'b0) begin errors++; $display("FAIL rmid_lsu_rvalid: got %b expected 0", lsu_rvalid); end
    @(negedge clk);
    rst_n = 1'b1;
    lsu_we = 1'b0; lsu_addr = 23'h0100;
    // A cleared counter lets the LSU win four more times before the forced fetch.
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      checks += 4;
      if (lsu_rvalid !== (i > 0))
        begin errors++; $display("FAIL rmid_post_lsu_rvalid[%0d]: got %b expected %b", i, lsu_rvalid, (i > 0)); end
      if (ifu_rvalid !== 1'b0)
        begin errors++; $display("FAIL rmid_post_ifu_rvalid[%0d]: got %b expected 0", i, ifu_rvalid); end
      if (ifu_gnt !== (i == 4))
        begin errors++; $display("FAIL rmid_post_ifu_gnt[%0d]: got %b expected %b", i, ifu_gnt, (i == 4)); end
      if (lsu_gnt !== (i != 4))
        begin errors++; $display("FAIL rmid_post_lsu_gnt[%0d]: got %b expected %b", i, lsu_gnt, (i != 4)); end
    end
    @(negedge clk);
    drive_idle();
  endtask

  task automatic test_random();
    for (int a = 0; a < 16; a++) preload(AW'(a), $urandom);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      ifu_req   = ($urandom % 4) != 0;
      ifu_flush = ($urandom % 8) == 0;
      lsu_req   = ($urandom % 2) != 0;
      lsu_we    = ($urandom % 2) != 0;
      lsu_be    = 4'($urandom);
      lsu_addr  = AW'($urandom % 16);
      ifu_addr  = AW'($urandom % 16);
      lsu_wdata = $urandom;
      #1;
      checks += 6;
      if (ifu_gnt !== f_ifu_gnt())   begin errors++; $display("FAIL rnd_ifu_gnt[%0d]: got %b expected %b", i, ifu_gnt, f_ifu_gnt()); end
      if (lsu_gnt !== f_lsu_gnt())   begin errors++; $display("FAIL rnd_lsu_gnt[%0d]: got %b expected %b", i, lsu_gnt, f_lsu_gnt()); end
      if (ram_wr !== f_wr())         begin errors++; $display("FAIL rnd_ram_wr[%0d]: got %h expected %h", i, ram_wr, f_wr()); end
      if (ram_addr !== f_addr())     begin errors++; $display("FAIL rnd_ram_addr[%0d]: got %h expected %h", i, ram_addr, f_addr()); end
      if (ifu_rvalid !== f_ifu_rv()) begin errors++; $display("FAIL rnd_ifu_rvalid[%0d]: got %b expected %b", i, ifu_rvalid, f_ifu_rv()); end
      if (lsu_rvalid !== f_lsu_rv()) begin errors++; $display("FAIL rnd_lsu_rvalid[%0d]: got %b expected %b", i, lsu_rvalid, f_lsu_rv()); end
      if (f_ifu_rv()) begin
        checks++;
        if (ifu_rdata !== m_data) begin errors++; $display("FAIL rnd_ifu_rdata[%0d]: got %h expected %h", i, ifu_rdata, m_data); end
      end
      if (f_lsu_rv()) begin
        checks++;
        if (lsu_rdata !== m_data) begin errors++; $display("FAIL rnd_lsu_rdata[%0d]: got %h expected %h", i, lsu_rdata, m_data); end
      end
    end
    @(negedge clk);
    drive_idle();
  endtask

  task automatic test_pure_lsu();
    @(negedge clk);
    drive_idle();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      ifu_req0 = 1'b1; lsu_req0 = 1'b1; lsu_we = 1'b0;
      #1;
      checks += 2;
      if (lsu_gnt0 !== 1'b1) begin errors++; $display("FAIL pure_lsu_gnt[%0d]: got %b expected 1", i, lsu_gnt0); end
      if (ifu_gnt0 !== 1'b0) begin errors++; $display("FAIL pure_ifu_gnt[%0d]: got %b expected 0", i, ifu_gnt0); end
    end
    @(negedge clk);
    drive_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    drive_idle();
    ifu_addr = '0; lsu_addr = '0; lsu_be = 4'h0; lsu_wdata = '0;
    test_reset();
    test_ifu_read();
    test_starvation();
    test_store_load();
    test_flush();
    test_reset_mid();
    test_random();
    test_pure_lsu();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
